// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LS chunk first,
// with a registered ripple carry and valid/ready handshakes on both sides.
`timescale 1ns/1ps
module chunked_addsub #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   generate
      if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("chunked_addsub: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [IDXW-1:0]  idx_q;
   logic             carry_q;
   logic [WIDTH-1:0] x_q;
   logic [WIDTH-1:0] yeff_q;
   logic [WIDTH-1:0] part_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;

   logic [CHUNK-1:0] x_chunk;
   logic [CHUNK-1:0] y_chunk;
   logic [CHUNK:0]   chunk_d;
   logic [WIDTH-1:0] part_d;
   logic             carry_d;
   logic             ovf_d;

   // One chunk of the ripple add; part_d already holds the merged result
   // so the final chunk can load sum/flags directly on the RUN->DONE edge.
   always_comb begin
      x_chunk = x_q[int'(idx_q)*CHUNK +: CHUNK];
      y_chunk = yeff_q[int'(idx_q)*CHUNK +: CHUNK];
      chunk_d = {1'b0, x_chunk} + {1'b0, y_chunk} + (CHUNK+1)'(carry_q);
      part_d  = part_q;
      part_d[int'(idx_q)*CHUNK +: CHUNK] = chunk_d[CHUNK-1:0];
      carry_d = chunk_d[CHUNK];
      ovf_d   = (x_q[WIDTH-1] == yeff_q[WIDTH-1]) && (part_d[WIDTH-1] != x_q[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         part_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  x_q     <= x;
                  yeff_q  <= sub ? ~y : y;
                  carry_q <= cin;
                  idx_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               part_q  <= part_d;
               carry_q <= carry_d;
               idx_q   <= idx_q + IDXW'(1);
               if (idx_q == LAST_IDX) begin
                  sum_q   <= part_d;
                  cout_q  <= carry_d;
                  ovf_q   <= ovf_d;
                  zero_q  <= (part_d == '0);
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule
